// File: rtl/rr_mux4x1.sv
// rtl/rr_mux4x1.sv - round-robin 4-to-1 gatherer of channel FIFOs, optional RR_SKIP_EMPTY_EN work-conserving grant
module rr_mux4x1 #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_0,
    input  logic [DATA_WIDTH-1:0] in_1,
    input  logic [DATA_WIDTH-1:0] in_2,
    input  logic [DATA_WIDTH-1:0] in_3,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic                  pause,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic [DATA_WIDTH-1:0] out_mux,
    output logic                  valid_out,
    output logic [1:0]            sel_out
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                state;
    logic [3:0]            empty_v;
    logic [3:0]            pop_v;
    logic [1:0]            ptr;
    logic [1:0]            ptr_next;
    logic [1:0]            grant_ch;
    logic                  grant_vld;
    logic [1:0]            cand;
    logic                  pend_valid;
    logic [1:0]            pend_ch;
    logic [DATA_WIDTH-1:0] in_sel;

    assign empty_v = {empty_3, empty_2, empty_1, empty_0};

    // Serving state follows the current inputs each cycle, so there is no dead cycle on entry or exit
    always_comb begin
        state = IDLE;
        if (reset && !pause && !(&empty_v)) begin
            state = ACTIVE;
        end
    end

    // Grant selection and pointer advance from the registered pointer and the live empty flags
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = ptr;
        ptr_next  = ptr;
        cand      = ptr;
        if (state == ACTIVE) begin
`ifdef RR_SKIP_EMPTY_EN
            // Descending scan so the smallest offset from ptr wins
            for (int i = 3; i >= 0; i--) begin
                cand = ptr + 2'(i);
                if (!empty_v[cand]) begin
                    grant_vld = 1'b1;
                    grant_ch  = cand;
                end
            end
            ptr_next = grant_ch + 2'd1;
`else
            grant_vld = !empty_v[ptr];
            ptr_next  = ptr + 2'd1;
`endif
        end
    end

    // One-hot read strobe for the granted channel only
    always_comb begin
        pop_v = 4'b0000;
        if (grant_vld) begin
            pop_v = 4'b0001 << grant_ch;
        end
    end

    assign pop_0 = pop_v[0];
    assign pop_1 = pop_v[1];
    assign pop_2 = pop_v[2];
    assign pop_3 = pop_v[3];

    // Select the FIFO read bus of the channel popped last cycle
    always_comb begin
        case (pend_ch)
            2'd0:    in_sel = in_0;
            2'd1:    in_sel = in_1;
            2'd2:    in_sel = in_2;
            default: in_sel = in_3;
        endcase
    end

    // Pointer, pop tracking and output stage; reset drops anything still in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr        <= 2'd0;
            pend_valid <= 1'b0;
            pend_ch    <= 2'd0;
            out_mux    <= '0;
            valid_out  <= 1'b0;
            sel_out    <= 2'd0;
        end else begin
            ptr        <= ptr_next;
            pend_valid <= grant_vld;
            pend_ch    <= grant_ch;
            valid_out  <= pend_valid;
            if (pend_valid) begin
                out_mux <= in_sel;
                sel_out <= pend_ch;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4x1.sv
// tb/tb_rr_mux4x1.sv - scoreboard bench for rr_mux4x1 with FIFO and grant models
module tb_rr_mux4x1;

    localparam int DW = 10;

    typedef struct {
        int          due;
        logic [1:0]  ch;
        logic [DW-1:0] data;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_v [4];
    logic [3:0]    empty_v;
    logic          pause;
    logic          pop_0, pop_1, pop_2, pop_3;
    logic [DW-1:0] out_mux;
    logic          valid_out;
    logic [1:0]    sel_out;

    logic [DW-1:0] fifo [4][$];
    sb_t           sb [$];

    logic          reset_c;
    logic          pause_c;
    logic [3:0]    force_c;
    logic          drv_pend [4];
    logic [DW-1:0] drv_val [4];
    bit            chk_en;
    int            cyc;
    logic [1:0]    ptr_m;
    logic [DW-1:0] last_out;
    logic [1:0]    last_sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_mux4x1 #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_0      (in_v[0]),
        .in_1      (in_v[1]),
        .in_2      (in_v[2]),
        .in_3      (in_v[3]),
        .empty_0   (empty_v[0]),
        .empty_1   (empty_v[1]),
        .empty_2   (empty_v[2]),
        .empty_3   (empty_v[3]),
        .pause     (pause),
        .pop_0     (pop_0),
        .pop_1     (pop_1),
        .pop_2     (pop_2),
        .pop_3     (pop_3),
        .out_mux   (out_mux),
        .valid_out (valid_out),
        .sel_out   (sel_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance n cycles; inputs change 1 time unit after the rising edge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk_en = 1'b1;
            for (int x = 0; x < 4; x++) begin
                if (drv_pend[x]) begin
                    in_v[x]     = drv_val[x];
                    drv_pend[x] = 1'b0;
                end
                empty_v[x] = (fifo[x].size() == 0) || force_c[x];
            end
            reset = reset_c;
            pause = pause_c;
        end
    endtask

    // Mid-cycle: score outputs, predict the grant, emulate the FIFOs' read side
    always @(negedge clk) begin
        logic [3:0]    exp_pop;
        logic [3:0]    act_pop;
        logic [1:0]    c;
        logic [DW-1:0] d;
        sb_t           e;
        if (chk_en) begin
            cyc++;
            act_pop = {pop_3, pop_2, pop_1, pop_0};
            if (valid_out) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.due);
                    check("out_mux", 32'(out_mux), 32'(e.data));
                    check("sel_out", 32'(sel_out), 32'(e.ch));
                    last_out = e.data;
                    last_sel = e.ch;
                end
            end else begin
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    check("missing_word", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
                check("hold_out", 32'(out_mux), 32'(last_out));
                check("hold_sel", 32'(sel_out), 32'(last_sel));
            end

            exp_pop = 4'b0000;
            if (!reset) begin
                ptr_m = 2'd0;
                while (sb.size() != 0 && sb[sb.size()-1].due > cyc) begin
                    void'(sb.pop_back());
                end
            end else if (!pause && empty_v != 4'hF) begin
`ifdef RR_SKIP_EMPTY_EN
                for (int i = 0; i < 4; i++) begin
                    c = ptr_m + 2'(i);
                    if (!empty_v[c]) begin
                        exp_pop[c] = 1'b1;
                        ptr_m = c + 2'd1;
                        break;
                    end
                end
`else
                if (!empty_v[ptr_m]) begin
                    exp_pop[ptr_m] = 1'b1;
                end
                ptr_m = ptr_m + 2'd1;
`endif
            end
            check("pop", 32'(act_pop), 32'(exp_pop));

            for (int x = 0; x < 4; x++) begin
                if (act_pop[x] === 1'b1) begin
                    if (fifo[x].size() == 0) begin
                        check("pop_of_empty", 32'd1, 32'd0);
                    end else begin
                        d = fifo[x].pop_front();
                        drv_pend[x] = 1'b1;
                        drv_val[x]  = d;
                        sb.push_back('{due: cyc + 2, ch: 2'(x), data: d});
                    end
                end
            end

            if (!reset) begin
                last_out = '0;
                last_sel = 2'd0;
            end
        end
    end

    initial begin
        reset    = 1'b0;
        pause    = 1'b0;
        empty_v  = 4'hF;
        reset_c  = 1'b0;
        pause_c  = 1'b0;
        force_c  = 4'h0;
        chk_en   = 1'b0;
        cyc      = 0;
        ptr_m    = 2'd0;
        last_out = '0;
        last_sel = 2'd0;
        for (int x = 0; x < 4; x++) begin
            in_v[x]     = '0;
            drv_pend[x] = 1'b0;
            drv_val[x]  = '0;
        end

        // Reset held 3 cycles with every FIFO non-empty, then fixed-slot sweep
        fifo[0].push_back(10'h001); fifo[0].push_back(10'h101);
        fifo[1].push_back(10'h002); fifo[1].push_back(10'h102);
        fifo[2].push_back(10'h003); fifo[2].push_back(10'h103);
        fifo[3].push_back(10'h3FF); fifo[3].push_back(10'h2FF);
        step(3);
        reset_c = 1'b1;
        step(12);

        // Sparse: only channel 2 has data
        for (int i = 0; i < 3; i++) fifo[2].push_back(10'h155);
        step(16);

        // Pause raised the cycle after pop_1
        reset_c = 1'b0;
        step(1);
        reset_c = 1'b1;
        for (int x = 0; x < 4; x++) fifo[x].push_back(10'(10'h010 * (x + 1)));
        step(2);
        pause_c = 1'b1;
        step(4);
        pause_c = 1'b0;
        step(8);

        // Empty race on channel 3 in its own slot
        reset_c = 1'b0;
        step(1);
        reset_c = 1'b1;
        for (int x = 0; x < 4; x++) fifo[x].push_back(10'(10'h0A0 + x));
        step(3);
        force_c[3] = 1'b1;
        step(1);
        force_c[3] = 1'b0;
        step(8);

        // Reset one cycle after pop_0
        reset_c = 1'b0;
        step(1);
        reset_c = 1'b1;
        fifo[0].push_back(10'h2AA);
        fifo[0].push_back(10'h0D5);
        step(1);
        reset_c = 1'b0;
        step(1);
        reset_c = 1'b1;
        step(8);

        // Random traffic with random pause
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                fifo[$urandom_range(0, 3)].push_back(10'($urandom));
            end
            pause_c = ($urandom_range(0, 3) == 0);
            step(1);
        end
        pause_c = 1'b0;
        step(60);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux4x1.md
Name: rr_mux4x1

Overview:
- Round-robin 4-to-1 gatherer. Drains four 10-bit channel FIFOs onto a single 10-bit stream.
- Tags each output word with its source channel so the 1-to-4 steering demux at the far end can route it back.
- Sits between the per-channel input FIFOs and the shared output path or downstream FIFO. Receive-side counterpart of the 4-way demux stage.

Parameters:
- DATA_WIDTH, 10, width of every channel word and of out_mux.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_0..in_3  input  DATA_WIDTH each  read-data buses of channel FIFOs 0..3; valid the cycle after the matching pop.
- empty_0..empty_3  input  1 each  channel FIFO empty flags; 1 = empty.
- pause  input  1  downstream almost-full; 1 = issue no new pops.
- pop_0..pop_3  output  1 each  FIFO read strobes; at most one high per cycle.
- out_mux  output  DATA_WIDTH  gathered data word.
- valid_out  output  1  out_mux/sel_out carry a new word this cycle.
- sel_out  output  2  source channel index of out_mux.

Behaviour:
- Reset: while reset==0 at a rising edge:
  - out_mux=0, valid_out=0, sel_out=0, ptr=0, pipeline stage cleared, FSM=IDLE.
  - pop_0..3 are forced to 0 combinationally whenever reset==0.
- Pointer: ptr[1:0] is the next channel to serve and wraps 3->0.
- FSM:
  - IDLE: all empty_x=1, or pause=1. No pops issued.
  - ACTIVE: at least one empty_x=0 and pause=0. Evaluated each cycle from current inputs; no dead cycle on transitions.
- Grant (ACTIVE, default build): pop_ptr = !empty_ptr. ptr increments by 1 every ACTIVE cycle whether or not a pop was issued.
- Pop is combinational from the registered ptr and the current flags. Only the granted channel's pop is high.
- Latency:
  - pop_x high in cycle N; FIFO drives in_x during N+1.
  - Block registers in_x into a stage register (data, channel index, valid) at the end of N+1.
  - out_mux=in_x, sel_out=x, valid_out=1 during cycle N+2.
  - Fixed pop-to-valid latency of 2 cycles. Back-to-back pops give one word per cycle.
- Hold: with no word arriving, valid_out=0; out_mux and sel_out hold their last values (not zeroed).
- pause:
  - Blocks new pops in the same cycle it is high.
  - Words already popped (up to 2 in flight) still complete. Downstream must absorb 2 words after raising pause.
  - ptr does not advance while pause=1.
- empty_x rising in the same cycle it would be granted: no pop to that channel. A pop is never issued to an empty FIFO.
- Reset mid-operation: in-flight words are discarded and are not presented on out_mux. The FIFO has already consumed them; this loss is accepted.
- Widths: sel_out equals the 2-bit index of the granted channel. No arithmetic on data.

Optional Feature:
- Macro: RR_SKIP_EMPTY_EN.
- Defined (work-conserving):
  - Grant goes to the first non-empty channel searched in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - After a grant to channel g, ptr = g+1 (mod 4).
  - If all channels are empty, no pop and ptr is unchanged.
- Undefined: fixed-slot behaviour as in Behaviour (one slot per cycle; empty slots are wasted).
- Latency, pause, and reset rules are identical in both builds.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all empty_x=0 -> pop_0..3=0, valid_out=0, out_mux=0, sel_out=0. First pop after release is pop_0.
- Fixed-slot sweep: all FIFOs non-empty (ch0=0x001, ch1=0x002, ch2=0x003, ch3=0x3FF), pause=0 -> pops 0,1,2,3,0 on consecutive cycles. out_mux 0x001,0x002,0x003,0x3FF, sel_out 0,1,2,3, first valid_out 2 cycles after pop_0.
- Sparse, undefined build: only ch2 non-empty (0x155) -> pop_2 once every 4 cycles, out_mux=0x155, sel_out=2. With RR_SKIP_EMPTY_EN: pop_2 every cycle until empty_2=1.
- Pause: raise pause in the cycle after pop_1 -> no further pops. valid_out still shows the ch0 and ch1 words, then 0. Drop pause -> next pop is pop_2.
- Empty race: empty_3 goes 1 in the cycle ptr=3 -> pop_3 stays 0 and no word with sel_out=3 appears.
- Mid-stream reset: reset=0 one cycle after pop_0 -> no valid_out for that word. After release, ptr=0 and service restarts at ch0.
